// File: rtl/vga_timing_if.sv
// VGA timing bundle: pixel/line counters plus sync, blank and frame-start flags.
// No latency of its own; it only carries what the timing generator drives.
// No backpressure; the timing stream is free-running.
interface vga_timing_if;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic        frame_start;

    modport master (
        output hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start
    );

    modport slave (
        input  hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Purpose: free-running VGA raster counters with registered sync/blank/frame-start flags.
// Latency: counts and flags change on the same edge, and flags always match the counts beside them.
// Backpressure: none; the generator advances one pixel per clock and never stalls.
module vga_timing #(
    parameter int H_TOT = 1344,
    parameter int H_SS  = 1048,
    parameter int H_SE  = 1184,
    parameter int H_BS  = 1024,
    parameter int V_TOT = 806,
    parameter int V_SS  = 771,
    parameter int V_SE  = 777,
    parameter int V_BS  = 768
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);

    localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOT - 1);
    localparam logic [10:0] H_SS_C  = 11'(H_SS);
    localparam logic [10:0] H_SE_C  = 11'(H_SE);
    localparam logic [10:0] H_BS_C  = 11'(H_BS);
    localparam logic [10:0] V_SS_C  = 11'(V_SS);
    localparam logic [10:0] V_SE_C  = 11'(V_SE);
    localparam logic [10:0] V_BS_C  = 11'(V_BS);

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic        frame_start;

    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic        h_wrap;
    logic        frame_nxt;

    // Next-state counts; ">=" on the wrap test pulls any out-of-range value back to 0.
    always_comb begin
        h_wrap    = (hcount >= H_LAST);
        h_nxt     = h_wrap ? 11'd0 : 11'(hcount + 11'd1);
        v_nxt     = vcount;
        frame_nxt = 1'b0;
        if (h_wrap) begin
            if (vcount >= V_LAST) begin
                v_nxt     = 11'd0;
                frame_nxt = 1'b1;
            end else begin
                v_nxt = 11'(vcount + 11'd1);
            end
        end
    end

    // Flags are decoded from the next counts so they register alongside them with zero skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hsync       <= 1'b0;
            hblnk       <= 1'b0;
            vsync       <= 1'b0;
            vblnk       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= (h_nxt >= H_SS_C) && (h_nxt < H_SE_C);
            hblnk       <= (h_nxt >= H_BS_C) && (h_nxt <= H_LAST);
            vsync       <= (v_nxt >= V_SS_C) && (v_nxt < V_SE_C);
            vblnk       <= (v_nxt >= V_BS_C) && (v_nxt <= V_LAST);
            frame_start <= frame_nxt;
        end
    end

    assign vga.hcount      = hcount;
    assign vga.vcount      = vcount;
    assign vga.hsync       = hsync;
    assign vga.hblnk       = hblnk;
    assign vga.vsync       = vsync;
    assign vga.vblnk       = vblnk;
    assign vga.frame_start = frame_start;

endmodule
